// File: rtl/axi_arb_rr.sv
// Read/write arbiter: NUM_M AXI masters onto one memory port plus a read-only CLINT port.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module axi_arb_rr #(
  parameter int          NUM_M      = 2,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_LAST = 32'h0200_ffff
) (
  input  logic                  clock,
  input  logic                  reset,
  // master-side AR/R
  input  logic [NUM_M-1:0]      m_arvalid,
  output logic [NUM_M-1:0]      m_arready,
  input  logic [NUM_M*32-1:0]   m_araddr,
  input  logic [NUM_M*4-1:0]    m_arid,
  input  logic [NUM_M*8-1:0]    m_arlen,
  input  logic [NUM_M*3-1:0]    m_arsize,
  input  logic [NUM_M*2-1:0]    m_arburst,
  output logic [NUM_M-1:0]      m_rvalid,
  input  logic [NUM_M-1:0]      m_rready,
  output logic [NUM_M-1:0]      m_rlast,
  output logic [NUM_M*32-1:0]   m_rdata,
  output logic [NUM_M*2-1:0]    m_rresp,
  output logic [NUM_M*4-1:0]    m_rid,
  // master-side AW/W/B
  input  logic [NUM_M-1:0]      m_awvalid,
  output logic [NUM_M-1:0]      m_awready,
  input  logic [NUM_M*32-1:0]   m_awaddr,
  input  logic [NUM_M*4-1:0]    m_awid,
  input  logic [NUM_M*8-1:0]    m_awlen,
  input  logic [NUM_M*3-1:0]    m_awsize,
  input  logic [NUM_M*2-1:0]    m_awburst,
  input  logic [NUM_M-1:0]      m_wvalid,
  output logic [NUM_M-1:0]      m_wready,
  input  logic [NUM_M*32-1:0]   m_wdata,
  input  logic [NUM_M*4-1:0]    m_wstrb,
  input  logic [NUM_M-1:0]      m_wlast,
  output logic [NUM_M-1:0]      m_bvalid,
  input  logic [NUM_M-1:0]      m_bready,
  output logic [NUM_M*2-1:0]    m_bresp,
  output logic [NUM_M*4-1:0]    m_bid,
  // memory-side port
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [31:0]           s_araddr,
  output logic [3:0]            s_arid,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [31:0]           s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic [3:0]            s_rid,
  input  logic                  s_rlast,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [31:0]           s_awaddr,
  output logic [3:0]            s_awid,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  output logic                  s_wlast,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp,
  input  logic [3:0]            s_bid,
  // CLINT read-only port
  output logic [31:0]           c_araddr,
  output logic                  c_arvalid,
  input  logic                  c_arready,
  input  logic [31:0]           c_rdata,
  input  logic [1:0]            c_rresp,
  input  logic                  c_rlast,
  input  logic [3:0]            c_rid,
  input  logic                  c_rvalid,
  output logic                  c_rready
);

  localparam int IW = (NUM_M > 2) ? 2 : 1;

  typedef enum logic [1:0] {R_IDLE, R_MEM, R_CLINT} rd_state_t;
  typedef enum logic       {W_IDLE, W_MEM}          wr_state_t;

  rd_state_t       rd_state;
  wr_state_t       wr_state;
  logic [IW-1:0]   rd_gnt, wr_gnt;
  logic [IW-1:0]   rd_win, wr_win;
  logic [IW-1:0]   rd_idx, wr_idx;
  logic            rd_any, wr_any;
  logic [31:0]     win_araddr;
  logic            win_is_clint;
  int              rg, wg;

`ifdef ARB_RR_EN
  logic [IW-1:0]   rd_ptr, wr_ptr;
`endif

  assign rg = int'(rd_gnt);
  assign wg = int'(wr_gnt);

  // Pick a winner from the valid vector seen in the IDLE cycle; the pointer (if any) names the top-priority master
  always_comb begin
    rd_win = '0;
    rd_any = 1'b0;
    wr_win = '0;
    wr_any = 1'b0;
    rd_idx = '0;
    wr_idx = '0;
    for (int off = 0; off < NUM_M; off++) begin
`ifdef ARB_RR_EN
      rd_idx = IW'((int'(rd_ptr) + off) % NUM_M);
      wr_idx = IW'((int'(wr_ptr) + off) % NUM_M);
`else
      rd_idx = IW'(off);
      wr_idx = IW'(off);
`endif
      if (!rd_any && m_arvalid[rd_idx]) begin
        rd_win = rd_idx;
        rd_any = 1'b1;
      end
      if (!wr_any && m_awvalid[wr_idx]) begin
        wr_win = wr_idx;
        wr_any = 1'b1;
      end
    end
  end

  assign win_araddr   = m_araddr[32*int'(rd_win) +: 32];
  assign win_is_clint = (win_araddr >= CLINT_BASE) && (win_araddr <= CLINT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      rd_gnt   <= '0;
`ifdef ARB_RR_EN
      rd_ptr   <= '0;
`endif
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_any) begin
            rd_gnt   <= rd_win;
            rd_state <= win_is_clint ? R_CLINT : R_MEM;
`ifdef ARB_RR_EN
            rd_ptr   <= IW'((int'(rd_win) + 1) % NUM_M);
`endif
          end
        end
        R_MEM:   if (s_rvalid && m_rready[rd_gnt] && s_rlast) rd_state <= R_IDLE;
        R_CLINT: if (c_rvalid && m_rready[rd_gnt] && c_rlast) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // CLINT-window writes are not special: every write goes to the memory port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state <= W_IDLE;
      wr_gnt   <= '0;
`ifdef ARB_RR_EN
      wr_ptr   <= '0;
`endif
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_any) begin
            wr_gnt   <= wr_win;
            wr_state <= W_MEM;
`ifdef ARB_RR_EN
            wr_ptr   <= IW'((int'(wr_win) + 1) % NUM_M);
`endif
          end
        end
        W_MEM:   if (s_bvalid && m_bready[wr_gnt]) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rid     = '0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = 1'b0;
    c_arvalid = 1'b0;
    c_araddr  = '0;
    c_rready  = 1'b0;
    case (rd_state)
      R_MEM: begin
        s_arvalid           = m_arvalid[rd_gnt];
        s_araddr            = m_araddr[32*rg +: 32];
        s_arid              = m_arid[4*rg +: 4];
        s_arlen             = m_arlen[8*rg +: 8];
        s_arsize            = m_arsize[3*rg +: 3];
        s_arburst           = m_arburst[2*rg +: 2];
        m_arready[rd_gnt]   = s_arready;
        m_rvalid[rd_gnt]    = s_rvalid;
        m_rlast[rd_gnt]     = s_rlast;
        m_rdata[32*rg +: 32] = s_rdata;
        m_rresp[2*rg +: 2]  = s_rresp;
        m_rid[4*rg +: 4]    = s_rid;
        s_rready            = m_rready[rd_gnt];
      end
      R_CLINT: begin
        c_arvalid           = m_arvalid[rd_gnt];
        c_araddr            = m_araddr[32*rg +: 32];
        m_arready[rd_gnt]   = c_arready;
        m_rvalid[rd_gnt]    = c_rvalid;
        m_rlast[rd_gnt]     = c_rlast;
        m_rdata[32*rg +: 32] = c_rdata;
        m_rresp[2*rg +: 2]  = c_rresp;
        m_rid[4*rg +: 4]    = c_rid;
        c_rready            = m_rready[rd_gnt];
      end
      default: ;
    endcase
  end

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_bid     = '0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    if (wr_state == W_MEM) begin
      s_awvalid          = m_awvalid[wr_gnt];
      s_awaddr           = m_awaddr[32*wg +: 32];
      s_awid             = m_awid[4*wg +: 4];
      s_awlen            = m_awlen[8*wg +: 8];
      s_awsize           = m_awsize[3*wg +: 3];
      s_awburst          = m_awburst[2*wg +: 2];
      m_awready[wr_gnt]  = s_awready;
      s_wvalid           = m_wvalid[wr_gnt];
      s_wdata            = m_wdata[32*wg +: 32];
      s_wstrb            = m_wstrb[4*wg +: 4];
      s_wlast            = m_wlast[wr_gnt];
      m_wready[wr_gnt]   = s_wready;
      m_bvalid[wr_gnt]   = s_bvalid;
      m_bresp[2*wg +: 2] = s_bresp;
      m_bid[4*wg +: 4]   = s_bid;
      s_bready           = m_bready[wr_gnt];
    end
  end

endmodule

// File: tb/tb_axi_arb_rr.sv
// Directed bench for axi_arb_rr with NUM_M=2; expected grant order follows ARB_RR_EN.
module tb_axi_arb_rr;

  logic        clock = 1'b0;
  logic        reset;

  logic [1:0]  m_arvalid, m_arready;
  logic [63:0] m_araddr;
  logic [7:0]  m_arid;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [1:0]  m_rvalid, m_rready, m_rlast;
  logic [63:0] m_rdata;
  logic [3:0]  m_rresp;
  logic [7:0]  m_rid;
  logic [1:0]  m_awvalid, m_awready;
  logic [63:0] m_awaddr;
  logic [7:0]  m_awid;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [3:0]  m_awburst;
  logic [1:0]  m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wlast;
  logic [1:0]  m_bvalid, m_bready;
  logic [3:0]  m_bresp;
  logic [7:0]  m_bid;

  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [3:0]  s_rid;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready, s_wlast;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic [3:0]  s_bid;

  logic [31:0] c_araddr, c_rdata;
  logic        c_arvalid, c_arready, c_rlast, c_rvalid, c_rready;
  logic [1:0]  c_rresp;
  logic [3:0]  c_rid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  axi_arb_rr #(.NUM_M(2)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .c_araddr(c_araddr), .c_arvalid(c_arvalid), .c_arready(c_arready), .c_rdata(c_rdata),
    .c_rresp(c_rresp), .c_rlast(c_rlast), .c_rid(c_rid), .c_rvalid(c_rvalid), .c_rready(c_rready)
  );

  // Quiescent inputs: slaves always ready, masters always accept responses, no requests pending
  task automatic idle_inputs;
    m_arvalid = '0; m_araddr = '0; m_arid = {4'd2, 4'd1}; m_arlen = '0;
    m_arsize = {3'd2, 3'd2}; m_arburst = {2'b01, 2'b01}; m_rready = 2'b11;
    m_awvalid = '0; m_awaddr = '0; m_awid = {4'd2, 4'd1}; m_awlen = '0;
    m_awsize = {3'd2, 3'd2}; m_awburst = {2'b01, 2'b01};
    m_wvalid = '0; m_wdata = '0; m_wstrb = 8'hff; m_wlast = 2'b11; m_bready = 2'b11;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 1'b0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0; s_bid = '0;
    c_arready = 1'b1; c_rdata = '0; c_rresp = '0; c_rlast = 1'b0; c_rid = '0; c_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11;
    s_rvalid = 1'b1; s_rdata = 32'hffff_ffff; s_bvalid = 1'b1; c_rvalid = 1'b1; c_rdata = 32'h5555_aaaa;
    repeat (2) @(negedge clock);
    #1;
    tests_run++; if (m_arready !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_m_arready: got %b expected 00", m_arready); end
    tests_run++; if (m_rvalid !== 2'b00 || m_rdata !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_m_r: rvalid=%b rdata=%h expected 00/0", m_rvalid, m_rdata); end
    tests_run++; if (s_arvalid !== 1'b0 || s_rready !== 1'b0 || c_arvalid !== 1'b0 || c_rready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_slave_side: s_arvalid=%b s_rready=%b c_arvalid=%b c_rready=%b expected 0", s_arvalid, s_rready, c_arvalid, c_rready); end
    tests_run++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || m_awready !== 2'b00 || m_bvalid !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_write_side: s_awvalid=%b s_wvalid=%b m_awready=%b m_bvalid=%b expected 0", s_awvalid, s_wvalid, m_awready, m_bvalid); end
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_two_masters;
    idle_inputs();
    m_araddr = {32'h8000_0000, 32'h8000_0000};
    m_arvalid = 2'b11;
    @(negedge clock); #1;
    tests_run++; if (m_arready !== 2'b01 || s_arid !== 4'd1) begin tests_failed++; $display("[TB] FAIL two_first_grant: m_arready=%b s_arid=%0d expected 01/1", m_arready, s_arid); end
    m_arvalid = 2'b10;
    @(negedge clock);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'ha0a0_0000; s_rid = 4'd1; #1;
    tests_run++; if (m_rvalid !== 2'b01 || m_rdata !== 64'h0000_0000_a0a0_0000 || m_rid !== 8'h01) begin tests_failed++; $display("[TB] FAIL two_first_data: rvalid=%b rdata=%h rid=%h expected 01/00000000a0a00000/01", m_rvalid, m_rdata, m_rid); end
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    tests_run++; if (m_arready !== 2'b00) begin tests_failed++; $display("[TB] FAIL two_idle_gap: m_arready=%b expected 00", m_arready); end
    @(negedge clock); #1;
    tests_run++; if (m_arready !== 2'b10 || s_arid !== 4'd2) begin tests_failed++; $display("[TB] FAIL two_second_grant: m_arready=%b s_arid=%0d expected 10/2", m_arready, s_arid); end
    m_arvalid = 2'b00;
    @(negedge clock);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h0000_00b1; s_rid = 4'd2; #1;
    tests_run++; if (m_rvalid !== 2'b10 || m_rdata !== 64'h0000_00b1_0000_0000) begin tests_failed++; $display("[TB] FAIL two_second_data: rvalid=%b rdata=%h expected 10/000000b100000000", m_rvalid, m_rdata); end
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic test_arb_sequence;
    logic [1:0] exp_seq [4];
    bit found;
`ifdef ARB_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
    idle_inputs();
    m_araddr = {32'h8000_0000, 32'h8000_0000};
    m_arvalid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clock); #1;
        if (m_arready !== 2'b00) found = 1'b1;
      end
      tests_run++; if (m_arready !== exp_seq[t]) begin tests_failed++; $display("[TB] FAIL arb_seq_grant%0d: m_arready=%b expected %b", t, m_arready, exp_seq[t]); end
      @(negedge clock);
      s_rvalid = 1'b1; s_rlast = 1'b1;
      @(negedge clock);
      s_rvalid = 1'b0; s_rlast = 1'b0;
    end
    m_arvalid = 2'b00;
    @(negedge clock);
  endtask

  task automatic test_clint;
    logic [31:0] addrs [4];
    bit          is_clint [4];
    addrs[0] = 32'h0200_0000; is_clint[0] = 1'b1;
    addrs[1] = 32'h0200_ffff; is_clint[1] = 1'b1;
    addrs[2] = 32'h0201_0000; is_clint[2] = 1'b0;
    addrs[3] = 32'h01ff_ffff; is_clint[3] = 1'b0;
    idle_inputs();
    m_araddr = {32'h0200_bff8, 32'h0};
    m_arvalid = 2'b10;
    @(negedge clock); #1;
    tests_run++; if (c_arvalid !== 1'b1 || s_arvalid !== 1'b0 || c_araddr !== 32'h0200_bff8 || m_arready !== 2'b10) begin tests_failed++; $display("[TB] FAIL clint_route: c_arvalid=%b s_arvalid=%b c_araddr=%h m_arready=%b expected 1/0/0200bff8/10", c_arvalid, s_arvalid, c_araddr, m_arready); end
    m_arvalid = 2'b00;
    @(negedge clock);
    c_rvalid = 1'b1; c_rlast = 1'b1; c_rdata = 32'h1234_5678; c_rid = 4'd2;
    s_rvalid = 1'b1; s_rdata = 32'hdead_0000; #1;
    tests_run++; if (m_rdata !== 64'h1234_5678_0000_0000 || m_rvalid !== 2'b10 || m_rlast !== 2'b10) begin tests_failed++; $display("[TB] FAIL clint_rdata: rdata=%h rvalid=%b rlast=%b expected 1234567800000000/10/10", m_rdata, m_rvalid, m_rlast); end
    tests_run++; if (c_rready !== 1'b1 || s_rready !== 1'b0) begin tests_failed++; $display("[TB] FAIL clint_rready: c_rready=%b s_rready=%b expected 1/0", c_rready, s_rready); end
    @(negedge clock);
    c_rvalid = 1'b0; c_rlast = 1'b0; s_rvalid = 1'b0; #1;
    tests_run++; if (m_rvalid !== 2'b00 || c_rready !== 1'b0) begin tests_failed++; $display("[TB] FAIL clint_release: m_rvalid=%b c_rready=%b expected 00/0", m_rvalid, c_rready); end
    for (int i = 0; i < 4; i++) begin
      m_araddr[31:0] = addrs[i];
      m_arvalid = 2'b01;
      @(negedge clock); #1;
      tests_run++; if (c_arvalid !== is_clint[i] || s_arvalid !== !is_clint[i]) begin tests_failed++; $display("[TB] FAIL clint_window_%h: c_arvalid=%b s_arvalid=%b expected %b/%b", addrs[i], c_arvalid, s_arvalid, is_clint[i], !is_clint[i]); end
      m_arvalid = 2'b00;
      @(negedge clock);
      if (is_clint[i]) begin c_rvalid = 1'b1; c_rlast = 1'b1; end
      else begin s_rvalid = 1'b1; s_rlast = 1'b1; end
      @(negedge clock);
      c_rvalid = 1'b0; c_rlast = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    end
  endtask

  task automatic test_concurrent;
    idle_inputs();
    m_araddr[31:0] = 32'h8000_0000; m_arlen[7:0] = 8'd3; m_arvalid = 2'b01;
    m_awaddr[63:32] = 32'h8000_0010; m_awvalid = 2'b10;
    m_wdata[63:32] = 32'hdead_beef; m_wvalid = 2'b10;
    @(negedge clock); #1;
    tests_run++; if (s_arvalid !== 1'b1 || s_arlen !== 8'd3 || m_arready !== 2'b01) begin tests_failed++; $display("[TB] FAIL conc_ar: s_arvalid=%b s_arlen=%0d m_arready=%b expected 1/3/01", s_arvalid, s_arlen, m_arready); end
    tests_run++; if (s_awvalid !== 1'b1 || s_awaddr !== 32'h8000_0010 || s_awid !== 4'd2 || m_awready !== 2'b10) begin tests_failed++; $display("[TB] FAIL conc_aw: s_awvalid=%b s_awaddr=%h s_awid=%0d m_awready=%b expected 1/80000010/2/10", s_awvalid, s_awaddr, s_awid, m_awready); end
    tests_run++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hdead_beef || m_wready !== 2'b10) begin tests_failed++; $display("[TB] FAIL conc_w: s_wvalid=%b s_wdata=%h m_wready=%b expected 1/deadbeef/10", s_wvalid, s_wdata, m_wready); end
    m_arvalid = 2'b00; m_awvalid = 2'b00; m_wvalid = 2'b00;
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      s_rvalid = 1'b1; s_rdata = 32'h100 + b; s_rlast = (b == 3); s_rid = 4'd1;
      if (b == 0) begin s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'd2; end
      else s_bvalid = 1'b0;
      #1;
      tests_run++; if (m_rvalid !== 2'b01 || m_rdata[31:0] !== 32'h100 + b || m_rlast !== ((b == 3) ? 2'b01 : 2'b00)) begin tests_failed++; $display("[TB] FAIL conc_beat%0d: rvalid=%b rdata=%h rlast=%b expected 01/%h/%b", b, m_rvalid, m_rdata[31:0], m_rlast, 32'h100 + b, (b == 3) ? 2'b01 : 2'b00); end
      if (b == 0) begin
        tests_run++; if (m_bvalid !== 2'b10 || m_bid !== 8'h20 || m_bresp !== 4'b0000) begin tests_failed++; $display("[TB] FAIL conc_b: bvalid=%b bid=%h bresp=%b expected 10/20/0000", m_bvalid, m_bid, m_bresp); end
      end
    end
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0; #1;
    tests_run++; if (s_rready !== 1'b0 || s_bready !== 1'b0) begin tests_failed++; $display("[TB] FAIL conc_done: s_rready=%b s_bready=%b expected 0/0", s_rready, s_bready); end
  endtask

  task automatic test_reset_mid_burst;
    idle_inputs();
    m_araddr[31:0] = 32'h8000_0000; m_arlen[7:0] = 8'd3; m_arvalid = 2'b01;
    @(negedge clock);
    m_arvalid = 2'b00;
    @(negedge clock);
    s_rvalid = 1'b1; s_rdata = 32'h1;
    @(negedge clock);
    s_rdata = 32'h2; #1;
    tests_run++; if (m_rvalid !== 2'b01) begin tests_failed++; $display("[TB] FAIL midrst_pre: m_rvalid=%b expected 01", m_rvalid); end
    reset = 1'b0; #1;
    tests_run++; if (m_rvalid !== 2'b00 || m_rdata !== 64'h0 || s_rready !== 1'b0 || m_arready !== 2'b00 || s_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_outputs: rvalid=%b rdata=%h s_rready=%b m_arready=%b s_arvalid=%b expected all 0", m_rvalid, m_rdata, s_rready, m_arready, s_arvalid); end
    @(negedge clock);
    s_rvalid = 1'b0; reset = 1'b1;
    @(negedge clock);
    m_araddr[63:32] = 32'h8000_0040; m_arvalid = 2'b10; #1;
    tests_run++; if (m_arready !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrst_no_early_grant: m_arready=%b expected 00", m_arready); end
    @(negedge clock); #1;
    tests_run++; if (m_arready !== 2'b10 || s_araddr !== 32'h8000_0040) begin tests_failed++; $display("[TB] FAIL midrst_new_grant: m_arready=%b s_araddr=%h expected 10/80000040", m_arready, s_araddr); end
    m_arvalid = 2'b00;
    @(negedge clock);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h77; #1;
    tests_run++; if (m_rdata !== 64'h0000_0077_0000_0000) begin tests_failed++; $display("[TB] FAIL midrst_new_data: rdata=%h expected 0000007700000000", m_rdata); end
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic test_write_arb;
    idle_inputs();
    m_awaddr = {32'h0200_0008, 32'h8000_0100};
    m_wdata = {32'h2222_2222, 32'h1111_1111};
    m_awvalid = 2'b11; m_wvalid = 2'b11;
    @(negedge clock); #1;
    tests_run++; if (m_awready !== 2'b01 || s_awaddr !== 32'h8000_0100 || s_wdata !== 32'h1111_1111) begin tests_failed++; $display("[TB] FAIL wr_first_grant: m_awready=%b s_awaddr=%h s_wdata=%h expected 01/80000100/11111111", m_awready, s_awaddr, s_wdata); end
    m_awvalid = 2'b10; m_wvalid = 2'b10;
    @(negedge clock);
    s_bvalid = 1'b1; s_bid = 4'd1; #1;
    tests_run++; if (m_bvalid !== 2'b01) begin tests_failed++; $display("[TB] FAIL wr_first_b: m_bvalid=%b expected 01", m_bvalid); end
    @(negedge clock);
    s_bvalid = 1'b0; #1;
    tests_run++; if (m_awready !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_idle_gap: m_awready=%b expected 00", m_awready); end
    @(negedge clock); #1;
    tests_run++; if (m_awready !== 2'b10 || s_awaddr !== 32'h0200_0008 || s_awvalid !== 1'b1 || c_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_clint_to_mem: m_awready=%b s_awaddr=%h s_awvalid=%b c_arvalid=%b expected 10/02000008/1/0", m_awready, s_awaddr, s_awvalid, c_arvalid); end
    m_awvalid = 2'b00; m_wvalid = 2'b00;
    @(negedge clock);
    s_bvalid = 1'b1; s_bid = 4'd2; s_bresp = 2'b10; #1;
    tests_run++; if (m_bvalid !== 2'b10 || m_bresp !== 4'b1000) begin tests_failed++; $display("[TB] FAIL wr_second_b: m_bvalid=%b m_bresp=%b expected 10/1000", m_bvalid, m_bresp); end
    @(negedge clock);
    s_bvalid = 1'b0; s_bresp = 2'b00;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_two_masters();
    test_arb_sequence();
    test_clint();
    test_concurrent();
    test_reset_mid_burst();
    test_write_arb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
